// File: rtl/input_interface_if.sv
// Host-side slice bus and core-side block handshake of the SHA-3 input stage.
// The slave modport is the input_interface view; the master modport is the
// view of whatever drives slices in and consumes blocks out.
interface input_interface_if;
    logic           pushin;
    logic [2:0]     dinix;
    logic [199:0]   din;
    logic [7:0]     tagin;
    logic           readyin;
    logic           stopout;
    logic           pushout;
    logic [1599:0]  dout;
    logic [7:0]     tagout;
    logic           errout;

    modport master (
        output pushin, dinix, din, tagin, readyin,
        input  stopout, pushout, dout, tagout, errout
    );

    modport slave (
        input  pushin, dinix, din, tagin, readyin,
        output stopout, pushout, dout, tagout, errout
    );
endinterface

// File: rtl/input_interface.sv
// input_interface: gathers eight 200-bit slices into a 1600-bit Keccak block
// with an 8-bit tag and hands it to the permutation core over valid/ready.
// Stage p0 is the assembly buffer (one complete block can wait there while
// the output register is occupied); stage p1 is the output register.
// Optional build macro: INPUT_INTERFACE_IXCHK_EN -- when defined, dinix is
// checked against the expected slot, bad indices are dropped with errout and
// a slice 0 arriving mid-block restarts assembly.
module input_interface (
    input  logic             clk,
    input  logic             reset,
    input_interface_if.slave bus
);
    logic [1599:0] blk_p0;
    logic [1599:0] blk_n;
    logic [7:0]    tag_p0;
    logic [2:0]    cnt_p0;
    logic          full_p0;
    logic [1599:0] dout_p1;
    logic [7:0]    tagout_p1;
    logic          vld_p1;
    logic          err_p1;

    logic [2:0]    slot;
    logic          accept;
    logic          err;
    logic          last;
    logic          out_free;
    logic          load_new;
    logic          load_buf;

`ifndef INPUT_INTERFACE_IXCHK_EN
    logic          unused_ix;
    assign unused_ix = ^bus.dinix;
`endif

    // Slice acceptance and protocol-violation decode.
    always_comb begin
        slot   = cnt_p0;
        accept = 1'b0;
        err    = 1'b0;
        if (bus.pushin) begin
            if (full_p0) begin
                err = 1'b1;
            end else begin
`ifdef INPUT_INTERFACE_IXCHK_EN
                if (bus.dinix == cnt_p0) begin
                    accept = 1'b1;
                end else if (bus.dinix == 3'd0) begin
                    // Abandon the partial block and start over at slot 0.
                    accept = 1'b1;
                    slot   = 3'd0;
                    err    = 1'b1;
                end else begin
                    err = 1'b1;
                end
`else
                accept = 1'b1;
`endif
            end
        end
    end

    // Next assembly-buffer contents with this cycle's slice merged in.
    always_comb begin
        blk_n = blk_p0;
        if (accept) begin
            blk_n[int'(slot) * 200 +: 200] = bus.din;
        end
    end

    assign last     = accept && (slot == 3'd7);
    assign out_free = !vld_p1 || bus.readyin;
    assign load_new = last && out_free;
    assign load_buf = full_p0 && vld_p1 && bus.readyin;

    // ---- p0: assembly buffer control (slot counter, full flag) ----
    // ---- p1: output valid and error pulse ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0  <= 3'd0;
            full_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            err_p1 <= err;
            if (accept) begin
                cnt_p0 <= slot + 3'd1;
            end
            if (last && !out_free) begin
                full_p0 <= 1'b1;
            end else if (load_buf) begin
                full_p0 <= 1'b0;
            end
            if (load_new || load_buf) begin
                vld_p1 <= 1'b1;
            end else if (bus.readyin) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // ---- p0/p1 data: buffer, pending tag, output block and tag ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_p0    <= '0;
            tag_p0    <= '0;
            dout_p1   <= '0;
            tagout_p1 <= '0;
        end else begin
            if (accept) begin
                blk_p0 <= blk_n;
            end
            if (accept && (slot == 3'd0)) begin
                tag_p0 <= bus.tagin;
            end
            if (load_new) begin
                dout_p1   <= blk_n;
                tagout_p1 <= tag_p0;
            end else if (load_buf) begin
                dout_p1   <= blk_p0;
                tagout_p1 <= tag_p0;
            end
        end
    end

    assign bus.stopout = full_p0;
    assign bus.pushout = vld_p1;
    assign bus.dout    = dout_p1;
    assign bus.tagout  = tagout_p1;
    assign bus.errout  = err_p1;
endmodule

// File: tb/tb_input_interface.sv
// Directed bench for input_interface: reset, single block, back-pressure with
// two blocks in flight, index handling (build-dependent) and async reset.
module tb_input_interface;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    input_interface_if bus();

    input_interface dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1599:0] mk_blk(input logic [7:0] base);
        logic [1599:0] b;
        logic [7:0]    p;
        for (int k = 0; k < 8; k++) begin
            p = base + 8'(k);
            b[k*200 +: 200] = {25{p}};
        end
        return b;
    endfunction

    function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
        for (int k = 0; k < 8; k++) begin
            if (a[k*200 +: 200] !== b[k*200 +: 200]) return k;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] ix, input logic [7:0] pat, input logic [7:0] tag);
        bus.pushin = 1'b1;
        bus.dinix  = ix;
        bus.din    = {25{pat}};
        bus.tagin  = tag;
        step();
        bus.pushin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.pushin = 1'b0; bus.dinix = '0; bus.din = '0; bus.tagin = '0; bus.readyin = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.pushout, bus.stopout, bus.errout, bus.tagout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got push=%b stop=%b err=%b tag=%h, expected all 0",
                     bus.pushout, bus.stopout, bus.errout, bus.tagout);
        end
        checks++;
        if (bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_dout: slice %0d got %h expected 0",
                     first_diff(bus.dout, '0), bus.dout[first_diff(bus.dout, '0)*200 +: 200]);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [1599:0] exp_blk;
        int errs_seen;
        exp_blk = mk_blk(8'h00);
        errs_seen = 0;
        bus.readyin = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(3'(k), 8'(k), (k == 0) ? 8'h5A : 8'hFF);
            if (bus.errout !== 1'b0) errs_seen++;
            if (k < 7) begin
                checks++;
                if (bus.pushout !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_push: slice %0d got %b expected 0", k, bus.pushout);
                end
            end
        end
        checks++;
        if (bus.pushout !== 1'b1) begin
            errors++;
            $display("FAIL basic_pushout: got %b expected 1", bus.pushout);
        end
        checks++;
        if (bus.dout !== exp_blk) begin
            errors++;
            $display("FAIL basic_dout: slice %0d got %h expected %h", first_diff(bus.dout, exp_blk),
                     bus.dout[first_diff(bus.dout, exp_blk)*200 +: 200],
                     exp_blk[first_diff(bus.dout, exp_blk)*200 +: 200]);
        end
        checks++;
        if (bus.tagout !== 8'h5A) begin
            errors++;
            $display("FAIL basic_tag: got %h expected 5a", bus.tagout);
        end
        checks++;
        if (errs_seen !== 0) begin
            errors++;
            $display("FAIL basic_errout: got %0d pulses expected 0", errs_seen);
        end
        step();
        checks++;
        if (bus.pushout !== 1'b0) begin
            errors++;
            $display("FAIL basic_pushout_clear: got %b expected 0", bus.pushout);
        end
        checks++;
        if (bus.dout !== exp_blk) begin
            errors++;
            $display("FAIL basic_dout_hold: slice %0d differs", first_diff(bus.dout, exp_blk));
        end
    endtask

    task automatic test_back_to_back();
        logic [1599:0] b1;
        logic [1599:0] b2;
        b1 = mk_blk(8'h10);
        b2 = mk_blk(8'h20);
        bus.readyin = 1'b0;
        for (int k = 0; k < 8; k++) push(3'(k), 8'h10 + 8'(k), 8'h21);
        for (int k = 0; k < 7; k++) push(3'(k), 8'h20 + 8'(k), 8'h22);
        checks++;
        if (bus.stopout !== 1'b0) begin
            errors++;
            $display("FAIL bp_stop_early: got %b expected 0", bus.stopout);
        end
        push(3'd7, 8'h27, 8'h22);
        checks++;
        if (bus.stopout !== 1'b1 || bus.pushout !== 1'b1) begin
            errors++;
            $display("FAIL bp_stop_rise: got stop=%b push=%b expected 1 1", bus.stopout, bus.pushout);
        end
        checks++;
        if (bus.dout !== b1 || bus.tagout !== 8'h21) begin
            errors++;
            $display("FAIL bp_hold_b1: slice %0d tag %h expected tag 21",
                     first_diff(bus.dout, b1), bus.tagout);
        end
        push(3'd0, 8'h33, 8'h99);
        checks++;
        if (bus.errout !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop_err: got %b expected 1", bus.errout);
        end
        step();
        checks++;
        if (bus.errout !== 1'b0 || bus.stopout !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_drop: got err=%b stop=%b expected 0 1", bus.errout, bus.stopout);
        end
        bus.readyin = 1'b1;
        step();
        bus.readyin = 1'b0;
        checks++;
        if (bus.dout !== b2 || bus.tagout !== 8'h22) begin
            errors++;
            $display("FAIL bp_b2_load: slice %0d got %h tag %h expected tag 22", first_diff(bus.dout, b2),
                     bus.dout[first_diff(bus.dout, b2)*200 +: 200], bus.tagout);
        end
        checks++;
        if (bus.pushout !== 1'b1 || bus.stopout !== 1'b0) begin
            errors++;
            $display("FAIL bp_stop_fall: got push=%b stop=%b expected 1 0", bus.pushout, bus.stopout);
        end
        bus.readyin = 1'b1;
        step();
        checks++;
        if (bus.pushout !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b expected 0", bus.pushout);
        end
    endtask

`ifdef INPUT_INTERFACE_IXCHK_EN
    task automatic test_index_skip();
        logic [1599:0] exp_blk;
        exp_blk = mk_blk(8'h40);
        bus.readyin = 1'b1;
        for (int k = 0; k < 3; k++) push(3'(k), 8'h40 + 8'(k), 8'h44);
        push(3'd5, 8'hEE, 8'h00);
        checks++;
        if (bus.errout !== 1'b1) begin
            errors++;
            $display("FAIL skip_err: got %b expected 1", bus.errout);
        end
        for (int k = 3; k < 8; k++) push(3'(k), 8'h40 + 8'(k), 8'h00);
        checks++;
        if (bus.pushout !== 1'b1 || bus.dout !== exp_blk || bus.tagout !== 8'h44) begin
            errors++;
            $display("FAIL skip_block: push=%b slice %0d tag %h expected push 1 tag 44",
                     bus.pushout, first_diff(bus.dout, exp_blk), bus.tagout);
        end
        step();
    endtask

    task automatic test_restart();
        logic [1599:0] exp_blk;
        int pulses;
        exp_blk = mk_blk(8'h80);
        pulses = 0;
        bus.readyin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(3'(k), 8'h50 + 8'(k), 8'h5A);
            pulses += int'(bus.errout);
        end
        push(3'd0, 8'h80, 8'h11);
        pulses += int'(bus.errout);
        for (int k = 1; k < 8; k++) begin
            push(3'(k), 8'h80 + 8'(k), 8'h00);
            pulses += int'(bus.errout);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL restart_err: got %0d pulses expected 1", pulses);
        end
        checks++;
        if (bus.pushout !== 1'b1 || bus.tagout !== 8'h11) begin
            errors++;
            $display("FAIL restart_tag: got push=%b tag=%h expected 1 11", bus.pushout, bus.tagout);
        end
        checks++;
        if (bus.dout !== exp_blk) begin
            errors++;
            $display("FAIL restart_dout: slice %0d got %h expected %h", first_diff(bus.dout, exp_blk),
                     bus.dout[first_diff(bus.dout, exp_blk)*200 +: 200],
                     exp_blk[first_diff(bus.dout, exp_blk)*200 +: 200]);
        end
        step();
    endtask
`else
    task automatic test_arrival_order();
        logic [1599:0] exp_blk;
        logic [7:0]    ixs [9];
        int pulses;
        ixs = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        for (int k = 0; k < 8; k++) exp_blk[k*200 +: 200] = {25{8'h40 + ixs[k]}};
        pulses = 0;
        bus.readyin = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push(ixs[k][2:0], 8'h40 + ixs[k], 8'h44);
            pulses += int'(bus.errout);
            if (k == 7) begin
                checks++;
                if (bus.pushout !== 1'b1 || bus.dout !== exp_blk || bus.tagout !== 8'h44) begin
                    errors++;
                    $display("FAIL order_block: push=%b slice %0d tag %h expected push 1 tag 44",
                             bus.pushout, first_diff(bus.dout, exp_blk), bus.tagout);
                end
            end
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL order_err: got %0d pulses expected 0", pulses);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [1599:0] exp_blk;
        exp_blk = mk_blk(8'h70);
        bus.readyin = 1'b0;
        for (int k = 0; k < 8; k++) push(3'(k), 8'h60 + 8'(k), 8'h66);
        for (int k = 0; k < 4; k++) push(3'(k), 8'h68 + 8'(k), 8'h67);
        checks++;
        if (bus.pushout !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got push=%b expected 1", bus.pushout);
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({bus.pushout, bus.stopout, bus.errout, bus.tagout} !== 11'd0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL mid_async: got push=%b stop=%b err=%b tag=%h dout_slice0=%h expected all 0",
                     bus.pushout, bus.stopout, bus.errout, bus.tagout, bus.dout[199:0]);
        end
        step();
        reset = 1'b1;
        step();
        bus.readyin = 1'b1;
        for (int k = 0; k < 8; k++) push(3'(k), 8'h70 + 8'(k), 8'h77);
        checks++;
        if (bus.pushout !== 1'b1 || bus.dout !== exp_blk || bus.tagout !== 8'h77) begin
            errors++;
            $display("FAIL mid_recover: push=%b slice %0d tag %h expected push 1 tag 77",
                     bus.pushout, first_diff(bus.dout, exp_blk), bus.tagout);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
`ifdef INPUT_INTERFACE_IXCHK_EN
        test_index_skip();
        test_restart();
`else
        test_arrival_order();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_interface.md
# input_interface

Front-end stage of the SHA-3 datapath. Collects eight 200-bit slices of a Keccak state from the host bus, assembles them into one 1600-bit block with its 8-bit tag, and presents the block to the permutation core through a valid/ready handshake. It is the mirror of the output slicer at the far end of the pipe. Slice 0 occupies bits 199:0 and slice 7 occupies bits 1599:1400.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it (low) clears all state immediately.
- pushin  in  1  slice valid this cycle.
- dinix  in  3  index of the slice on din; 0..7.
- din  in  200  slice data.
- tagin  in  8  block tag; sampled with slice 0 only.
- readyin  in  1  permutation core accepts the block on this edge.
- stopout  out  1  registered; upstream must not assert pushin while this is high.
- pushout  out  1  block valid on dout/tagout.
- dout  out  1600  assembled block.
- tagout  out  8  tag of the block on dout.
- errout  out  1  one-cycle pulse on a protocol violation.

## Operation
- Assembly buffer: 1600 bits, 3-bit slot counter `cnt` (0..7) and a `full` flag. Output register: 1600 bits, `pushout` and tagout.
- A slice is accepted when pushin=1, stopout=0 and, with checking enabled, dinix==cnt. An accepted slice writes din into buffer bits [200·cnt+199 : 200·cnt].
- On accepting slice 0, tagin is latched as the pending tag.
- On accepting slice 7, cnt wraps to 0.
  - If the output register is free (pushout=0, or pushout=1 with readyin=1 on the same edge), the complete block goes straight into the output register, including this edge's slice 7. pushout=1 after the edge.
  - Otherwise the buffer sets `full`.
- While `full`=1 and the output register frees (pushout&readyin), the buffer moves to the output register and `full` clears on that edge.
- pushout clears on an edge with readyin=1 and no new block loaded.
- stopout next = `full` next. In other words, stopout is high exactly while a complete block is waiting.
- Violations cause errout to pulse for one cycle and leave state untouched except as noted:
  - pushin while stopout=1: the slice is dropped.
  - dinix≠cnt and dinix≠0: the slice is dropped and cnt is unchanged.
  - dinix=0 with cnt≠0: the partial block is abandoned, cnt restarts, slice 0 is accepted, and the new tag is latched.
- dout and tagout hold their value while pushout=0. They are not cleared on handoff.

## Timing
- Reset values: pushout=0, stopout=0, errout=0, dout=0, tagout=0, cnt=0, full=0.
- Reset mid-block discards the partial block. Reset with pushout=1 drops the pending block.
- Latency: slice 7 accepted at edge N means pushout=1 and dout valid after edge N.
- Throughput: one slice per cycle. A block stream is sustained with no bubbles when readyin is high.
- Buffering: at most two blocks are in flight (one in the output register, one full in the buffer). stopout rises after the edge that sets `full` and falls after the edge that clears it.
- A handoff and the acceptance of slice 7 can happen on the same edge. This is legal and does not stall.
- readyin while pushout=0 is ignored.

## Configuration
- INPUT_INTERFACE_IXCHK_EN defined: dinix is checked against cnt as described above, and errout reports index violations.
- INPUT_INTERFACE_IXCHK_EN undefined: dinix is ignored and slices fill slots strictly in arrival order 0..7. errout pulses only for pushin while stopout=1.

## Test plan
- Reset low, release, push slices 0..7 (slice k = k replicated across bits, tagin=0x5A on slice 0), readyin=1 → pushout is high for one cycle after slice 7; dout[200k+199:200k] equals slice k; tagout=0x5A.
- Two back-to-back blocks with readyin held at 0 → stopout rises after slice 7 of block 2; a 17th push is dropped and errout pulses. readyin=1 for one cycle → block 1 leaves, block 2 loads, and stopout falls on the next edge.
- Slices 0,1,2,5 (IXCHK_EN defined) → slice 5 is dropped with an errout pulse; sending 3..7 then completes the correct block.
- Slices 0..3, then a slice 0 with tagin=0x11, then 1..7 → one errout pulse; the delivered block carries tagout=0x11 and only the new slices.
- Assert reset while cnt=4 and pushout=1 → all outputs are 0 immediately; a full block then sent completes normally.
- Same stimulus as scenario 3 with IXCHK_EN undefined → no errout; slices are placed by arrival order.
